apu_reg_file: RTL and testbench

APU_REG_FILE -- requirements
Module: apu_reg_file

---
 rtl/apu_pkg.sv | 27 ++
 rtl/apu_reg_file_if.sv | 41 ++++
 rtl/apu.sv | 158 +++++++++++++++
 rtl/reg_file.sv | 38 +++
 rtl/apu_reg_file.sv | 54 +++++
 tb/tb_apu_reg_file.sv | 230 +++++++++++++++++++++++
 6 files changed

// File: rtl/apu_pkg.sv
// apu_pkg: shared widths, opcode constants and FSM state type for the
// apu_reg_file slice (serial divide unit + 32-entry register file).
package apu_pkg;

  localparam int data_width    = 32;
  localparam int reg_sel_width = 5;
  localparam int num_regs      = 32;
  localparam int funct_width   = 10;

  // {funct7, funct3} of the RISC-V M-extension divide group.
  localparam logic [funct_width-1:0] FUNCT_DIV  = 10'b0000001_100;
  localparam logic [funct_width-1:0] FUNCT_DIVU = 10'b0000001_101;
  localparam logic [funct_width-1:0] FUNCT_REM  = 10'b0000001_110;
  localparam logic [funct_width-1:0] FUNCT_REMU = 10'b0000001_111;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DIVIDE    = 2'd1,
    ST_WRITEBACK = 2'd2
  } apu_state_t;

  // The four supported codes share funct7=0000001 and funct3[2]=1.
  function automatic logic funct_legal(input logic [funct_width-1:0] f);
    return (f[9:3] == 7'b0000001) && f[2];
  endfunction

endpackage

// File: rtl/apu_reg_file_if.sv
// apu_reg_file_if: bundles the request side, the write-back observation
// signals, the processor read ports and the divider state for debug.
//   master : drives req/rs1/rs2/rd_sel/funct and the read-port selects
//   slave  : drives busy, apu_wr_*, proc_rs*_data and apu_state
//
// Handshake: a request is the pair (req, operands) sampled on a rising
// clk edge. It is taken when the unit is idle and funct is legal; busy is
// the combinational "rejected" answer, high only while req=1 and an
// operation is in progress. A rejected or illegal request is simply lost;
// the requester must present it again.
interface apu_reg_file_if;
  import apu_pkg::*;

  logic                     req;
  logic [data_width-1:0]    rs1;
  logic [data_width-1:0]    rs2;
  logic [reg_sel_width-1:0] rd_sel;
  logic [funct_width-1:0]   funct;
  logic                     busy;
  logic                     apu_wr_req;
  logic [reg_sel_width-1:0] apu_wr_sel;
  logic [data_width-1:0]    apu_wr_data;
  logic [reg_sel_width-1:0] proc_rs1_sel;
  logic [reg_sel_width-1:0] proc_rs2_sel;
  logic [data_width-1:0]    proc_rs1_data;
  logic [data_width-1:0]    proc_rs2_data;
  apu_state_t               apu_state;

  modport master (
    output req, rs1, rs2, rd_sel, funct, proc_rs1_sel, proc_rs2_sel,
    input  busy, apu_wr_req, apu_wr_sel, apu_wr_data,
           proc_rs1_data, proc_rs2_data, apu_state
  );

  modport slave (
    input  req, rs1, rs2, rd_sel, funct, proc_rs1_sel, proc_rs2_sel,
    output busy, apu_wr_req, apu_wr_sel, apu_wr_data,
           proc_rs1_data, proc_rs2_data, apu_state
  );

endinterface

// File: rtl/apu.sv
// apu: request capture plus a restoring serial divider (one quotient bit
// per cycle, 32 iterations) for DIV/DIVU/REM/REMU.
// Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_req, i_rs1, i_rs2,  request and operands, sampled on rising clk
//   i_rd_sel, i_funct
//   i_ack                 write-back accepted by the register file
//   o_busy                request rejected (combinational)
//   o_wr_req/sel/data     registered write-back strobe, index, value
//   o_state               FSM state for debug
// Timing: accept at edge E0, iterations at E1..E32, o_wr_req high for the
// cycle after E33, back to idle at E34 when the register file writes.
module apu
  import apu_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req,
  input  logic [data_width-1:0]    i_rs1,
  input  logic [data_width-1:0]    i_rs2,
  input  logic [reg_sel_width-1:0] i_rd_sel,
  input  logic [funct_width-1:0]   i_funct,
  input  logic                     i_ack,
  output logic                     o_busy,
  output logic                     o_wr_req,
  output logic [reg_sel_width-1:0] o_wr_sel,
  output logic [data_width-1:0]    o_wr_data,
  output apu_state_t               o_state
);

  localparam logic [5:0] LAST_COUNT = 6'd32;

  apu_state_t               r_state;
  apu_state_t               w_next;
  logic [5:0]               r_count;
  logic [data_width-1:0]    r_quo;
  logic [data_width-1:0]    r_rem;
  logic [data_width-1:0]    r_dvs;
  logic                     r_is_rem;
  logic                     r_neg_q;
  logic                     r_neg_r;
  logic [reg_sel_width-1:0] r_rd;
  logic                     r_wr_req;
  logic [reg_sel_width-1:0] r_wr_sel;
  logic [data_width-1:0]    r_wr_data;

  logic                     w_accept;
  logic                     w_iterate;
  logic                     w_finish;
  logic                     w_signed;
  logic                     w_rs1_neg;
  logic                     w_rs2_neg;
  logic [data_width-1:0]    w_abs1;
  logic [data_width-1:0]    w_abs2;
  logic [data_width:0]      w_shift;
  logic [data_width-1:0]    w_diff;
  logic                     w_ge;
  logic [data_width-1:0]    w_quo_fix;
  logic [data_width-1:0]    w_rem_fix;
  logic [data_width-1:0]    w_result;

  // funct3[0]=0 selects the signed forms, funct3[1]=1 the remainder forms.
  assign w_signed  = ~i_funct[0];
  assign w_rs1_neg = w_signed & i_rs1[data_width-1];
  assign w_rs2_neg = w_signed & i_rs2[data_width-1];
  assign w_abs1    = w_rs1_neg ? -i_rs1 : i_rs1;
  assign w_abs2    = w_rs2_neg ? -i_rs2 : i_rs2;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits.
  assign w_shift = {r_rem, r_quo[data_width-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift[data_width-1:0] - r_dvs;

  assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fix = r_neg_r ? -r_rem : r_rem;
  assign w_result  = r_is_rem ? w_rem_fix : w_quo_fix;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (i_req && funct_legal(i_funct)) w_next = ST_DIVIDE;
      ST_DIVIDE:    if (r_count == LAST_COUNT)         w_next = ST_WRITEBACK;
      ST_WRITEBACK: if (i_ack)                         w_next = ST_IDLE;
      default:                                         w_next = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_accept  = 1'b0;
    w_iterate = 1'b0;
    w_finish  = 1'b0;
    o_busy    = 1'b0;
    case (r_state)
      ST_IDLE: w_accept = i_req & funct_legal(i_funct);
      ST_DIVIDE: begin
        w_iterate = (r_count != LAST_COUNT);
        w_finish  = (r_count == LAST_COUNT);
        o_busy    = i_req;
      end
      ST_WRITEBACK: o_busy = i_req;
      default: ;
    endcase
  end

  // Datapath and registered write-back outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count   <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_dvs     <= '0;
      r_is_rem  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rd      <= '0;
      r_wr_req  <= 1'b0;
      r_wr_sel  <= '0;
      r_wr_data <= '0;
    end else begin
      if (w_accept) begin
        r_count  <= '0;
        r_quo    <= w_abs1;
        r_rem    <= '0;
        r_dvs    <= w_abs2;
        r_is_rem <= i_funct[1];
        // A zero divisor already yields all-ones magnitude; keeping the
        // quotient un-negated makes signed x/0 return all-ones too.
        r_neg_q  <= (w_rs1_neg ^ w_rs2_neg) & (i_rs2 != '0);
        r_neg_r  <= w_rs1_neg;
        r_rd     <= i_rd_sel;
      end else if (w_iterate) begin
        r_count <= r_count + 6'd1;
        r_quo   <= {r_quo[data_width-2:0], w_ge};
        r_rem   <= w_ge ? w_diff : w_shift[data_width-1:0];
      end
      r_wr_req <= w_finish;
      if (w_finish) begin
        r_wr_sel  <= r_rd;
        r_wr_data <= w_result;
      end
    end
  end

  assign o_wr_req  = r_wr_req;
  assign o_wr_sel  = r_wr_sel;
  assign o_wr_data = r_wr_data;
  assign o_state   = r_state;

endmodule

// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit registers, one write port fed by the apu and two
// combinational processor read ports. Register 0 reads as zero and is
// never written. The write port always accepts (o_ack = i_wr_req).
// Ports:
//   i_clk, i_rst                 clock, async active-high reset (clears all)
//   i_wr_req/sel/data, o_ack     write port from the apu
//   i_rs1_sel/o_rs1_data,        processor read ports
//   i_rs2_sel/o_rs2_data
module reg_file
  import apu_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_req,
  input  logic [reg_sel_width-1:0] i_wr_sel,
  input  logic [data_width-1:0]    i_wr_data,
  output logic                     o_ack,
  input  logic [reg_sel_width-1:0] i_rs1_sel,
  input  logic [reg_sel_width-1:0] i_rs2_sel,
  output logic [data_width-1:0]    o_rs1_data,
  output logic [data_width-1:0]    o_rs2_data
);

  logic [data_width-1:0] r_regs [num_regs];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < num_regs; i++) r_regs[i] <= '0;
    end else if (i_wr_req && (i_wr_sel != '0)) begin
      r_regs[i_wr_sel] <= i_wr_data;
    end
  end

  assign o_ack      = i_wr_req;
  assign o_rs1_data = (i_rs1_sel == '0) ? '0 : r_regs[i_rs1_sel];
  assign o_rs2_data = (i_rs2_sel == '0) ? '0 : r_regs[i_rs2_sel];

endmodule

// File: rtl/apu_reg_file.sv
// apu_reg_file: top of the slice. The apu divides and writes its result
// back into reg_file through apu_wr_req/apu_ack/apu_wr_sel/apu_wr_data;
// the processor reads registers through two combinational ports.
// Ports:
//   clk, rst   clock, async active-high reset
//   bus        apu_reg_file_if.slave (request, busy, write-back view,
//              read ports, divider state)
module apu_reg_file
  import apu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  apu_reg_file_if.slave  bus
);

  logic                     w_apu_wr_req;
  logic                     w_apu_ack;
  logic [reg_sel_width-1:0] w_apu_wr_sel;
  logic [data_width-1:0]    w_apu_wr_data;

  apu u_apu (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (bus.req),
    .i_rs1     (bus.rs1),
    .i_rs2     (bus.rs2),
    .i_rd_sel  (bus.rd_sel),
    .i_funct   (bus.funct),
    .i_ack     (w_apu_ack),
    .o_busy    (bus.busy),
    .o_wr_req  (w_apu_wr_req),
    .o_wr_sel  (w_apu_wr_sel),
    .o_wr_data (w_apu_wr_data),
    .o_state   (bus.apu_state)
  );

  reg_file u_reg_file (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wr_req   (w_apu_wr_req),
    .i_wr_sel   (w_apu_wr_sel),
    .i_wr_data  (w_apu_wr_data),
    .o_ack      (w_apu_ack),
    .i_rs1_sel  (bus.proc_rs1_sel),
    .i_rs2_sel  (bus.proc_rs2_sel),
    .o_rs1_data (bus.proc_rs1_data),
    .o_rs2_data (bus.proc_rs2_data)
  );

  assign bus.apu_wr_req  = w_apu_wr_req;
  assign bus.apu_wr_sel  = w_apu_wr_sel;
  assign bus.apu_wr_data = w_apu_wr_data;

endmodule

// File: tb/tb_apu_reg_file.sv
// tb_apu_reg_file: directed bench for apu_reg_file. Inputs change 1 time
// unit after a rising edge; outputs are read at the same offset.
module tb_apu_reg_file;
  import apu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apu_reg_file_if bus();

  apu_reg_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int pulses     = 0;

  always @(posedge clk) cyc <= cyc + 1;
  // A write-back pulse spans one full cycle, so it covers exactly one negedge.
  always @(negedge clk) if (bus.apu_wr_req === 1'b1) pulses <= pulses + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [9:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    bus.req    = 1'b1;
    bus.funct  = f;
    bus.rs1    = a;
    bus.rs2    = b;
    bus.rd_sel = rd;
  endtask

  // Wait for the write-back of an operation accepted at cycle acc and check
  // latency, index, value, the single pulse and the register read-back.
  task automatic finish_op(input string tag, input int acc, input int p0,
                           input logic [4:0] rd, input logic [31:0] exp);
    int n;
    n = 0;
    while (bus.apu_wr_req !== 1'b1 && n < 45) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(cyc - acc), 32'd33);
    chk({tag, "_sel"}, 32'(bus.apu_wr_sel), 32'(rd));
    chk({tag, "_data"}, bus.apu_wr_data, exp);
    tick();
    chk({tag, "_wr_low"}, 32'(bus.apu_wr_req), 32'd0);
    bus.proc_rs1_sel = rd;
    bus.proc_rs2_sel = rd;
    #1;
    chk({tag, "_rd1"}, bus.proc_rs1_data, (rd == 5'd0) ? 32'd0 : exp);
    chk({tag, "_rd2"}, bus.proc_rs2_data, (rd == 5'd0) ? 32'd0 : exp);
    chk({tag, "_pulses"}, 32'(pulses - p0), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [9:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int acc;
    int p0;
    p0 = pulses;
    drive(f, a, b, rd);
    tick();
    acc = cyc;
    // Scramble operands after acceptance; the captured copy must be used.
    bus.req    = 1'b0;
    bus.rs1    = ~a;
    bus.rs2    = ~b;
    bus.rd_sel = ~rd;
    #1;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    finish_op(tag, acc, p0, rd, exp);
  endtask

  initial begin
    int acc;
    int p0;
    rst              = 1'b1;
    bus.req          = 1'b0;
    bus.rs1          = '0;
    bus.rs2          = '0;
    bus.rd_sel       = '0;
    bus.funct        = '0;
    bus.proc_rs1_sel = '0;
    bus.proc_rs2_sel = '0;
    #2;

    // Reset state
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_wr_req", 32'(bus.apu_wr_req), 32'd0);
    chk("rst_wr_sel", 32'(bus.apu_wr_sel), 32'd0);
    chk("rst_wr_data", bus.apu_wr_data, 32'd0);
    chk("rst_state", 32'(bus.apu_state), 32'(ST_IDLE));
    bus.proc_rs1_sel = 5'd5;
    bus.proc_rs2_sel = 5'd31;
    #1;
    chk("rst_rd_r5", bus.proc_rs1_data, 32'd0);
    chk("rst_rd_r31", bus.proc_rs2_data, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Basic DIVU
    do_op("divu_1234_53", FUNCT_DIVU, 32'd1234, 32'd53, 5'd11, 32'd23);

    // Request rejected while dividing
    p0 = pulses;
    drive(FUNCT_DIVU, 32'd55555, 32'd173, 5'd7);
    tick();
    acc = cyc;
    bus.req = 1'b0;
    tick();
    #1;
    chk("rej_busy_low", 32'(bus.busy), 32'd0);
    tick();
    drive(FUNCT_DIVU, 32'd100, 32'd3, 5'd9);
    #1;
    chk("rej_busy_high", 32'(bus.busy), 32'd1);
    tick();
    bus.req = 1'b0;
    #1;
    chk("rej_busy_drop", 32'(bus.busy), 32'd0);
    chk("rej_state", 32'(bus.apu_state), 32'(ST_DIVIDE));
    finish_op("divu_55555_173", acc, p0, 5'd7, 32'd321);
    bus.proc_rs1_sel = 5'd9;
    #1;
    chk("rej_no_write_r9", bus.proc_rs1_data, 32'd0);

    // Request during the write-back cycle is rejected, next cycle accepted
    p0 = pulses;
    drive(FUNCT_DIVU, 32'd100, 32'd7, 5'd3);
    tick();
    acc = cyc;
    bus.req = 1'b0;
    while (bus.apu_wr_req !== 1'b1 && (cyc - acc) < 45) tick();
    chk("wb_lat", 32'(cyc - acc), 32'd33);
    chk("wb_data", bus.apu_wr_data, 32'd14);
    drive(FUNCT_DIVU, 32'd9, 32'd2, 5'd4);
    #1;
    chk("wb_busy_high", 32'(bus.busy), 32'd1);
    tick();
    chk("wb_busy_idle", 32'(bus.busy), 32'd0);
    chk("wb_state_idle", 32'(bus.apu_state), 32'(ST_IDLE));
    p0 = pulses;
    tick();
    acc = cyc;
    bus.req = 1'b0;
    bus.proc_rs1_sel = 5'd3;
    #1;
    chk("wb_r3", bus.proc_rs1_data, 32'd14);
    finish_op("wb_next_9_2", acc, p0, 5'd4, 32'd4);

    // Signed variants and corner cases
    do_op("div_m7_2",    FUNCT_DIV,  32'hFFFF_FFF9, 32'd2,        5'd1,  32'hFFFF_FFFD);
    do_op("rem_m7_2",    FUNCT_REM,  32'hFFFF_FFF9, 32'd2,        5'd2,  32'hFFFF_FFFF);
    do_op("div_7_m2",    FUNCT_DIV,  32'd7,         32'hFFFF_FFFE, 5'd12, 32'hFFFF_FFFD);
    do_op("rem_7_m2",    FUNCT_REM,  32'd7,         32'hFFFF_FFFE, 5'd13, 32'd1);
    do_op("div_ovf",     FUNCT_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000);
    do_op("rem_ovf",     FUNCT_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0);
    do_op("divu_by0",    FUNCT_DIVU, 32'h1234_5678, 32'd0,        5'd16, 32'hFFFF_FFFF);
    do_op("remu_5_by0",  FUNCT_REMU, 32'd5,         32'd0,        5'd17, 32'd5);
    do_op("div_m9_by0",  FUNCT_DIV,  32'hFFFF_FFF7, 32'd0,        5'd18, 32'hFFFF_FFFF);
    do_op("rem_m9_by0",  FUNCT_REM,  32'hFFFF_FFF7, 32'd0,        5'd19, 32'hFFFF_FFF7);
    do_op("remu_big",    FUNCT_REMU, 32'hFFFF_FFFF, 32'd10,       5'd22, 32'd5);

    // Write to register 0 still pulses but reads back zero
    do_op("divu_r0", FUNCT_DIVU, 32'd1000, 32'd8, 5'd0, 32'd125);

    // Unsupported funct is dropped
    p0 = pulses;
    drive(10'b0000000_000, 32'd10, 32'd2, 5'd20);
    #1;
    chk("ill_busy", 32'(bus.busy), 32'd0);
    tick();
    bus.req = 1'b0;
    #1;
    chk("ill_state", 32'(bus.apu_state), 32'(ST_IDLE));
    repeat (40) tick();
    chk("ill_no_pulse", 32'(pulses - p0), 32'd0);
    bus.proc_rs1_sel = 5'd20;
    #1;
    chk("ill_r20", bus.proc_rs1_data, 32'd0);

    // Reset at iteration 10 aborts the operation and clears registers
    p0 = pulses;
    drive(FUNCT_DIVU, 32'd1000, 32'd10, 5'd21);
    tick();
    bus.req = 1'b0;
    repeat (10) tick();
    chk("mid_state", 32'(bus.apu_state), 32'(ST_DIVIDE));
    rst = 1'b1;
    bus.proc_rs1_sel = 5'd11;
    bus.req = 1'b1;
    #1;
    chk("mid_rst_state", 32'(bus.apu_state), 32'(ST_IDLE));
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_wr_req", 32'(bus.apu_wr_req), 32'd0);
    chk("mid_rst_r11", bus.proc_rs1_data, 32'd0);
    bus.req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (40) tick();
    chk("mid_no_pulse", 32'(pulses - p0), 32'd0);
    bus.proc_rs1_sel = 5'd21;
    #1;
    chk("mid_r21", bus.proc_rs1_data, 32'd0);
    do_op("after_rst", FUNCT_DIVU, 32'd1000, 32'd10, 5'd21, 32'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
